// File: rtl/skip_pkg.sv
// Shared types and helpers for the clock-skip ring control stage.
// State encoding, default geometry and the skip-count clamp.
package skip_pkg;

   localparam int LEN_DEF = 16;
   localparam int CW_DEF  = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GEN   = 2'd1,
      S_LOAD1 = 2'd2,
      S_LOAD2 = 2'd3
   } skip_state_e;

   // At least one pulse per ring period must always pass.
   function automatic int clamp_cnt(input int cnt, input int len);
      return (cnt > len - 1) ? len - 1 : cnt;
   endfunction

endpackage

// File: rtl/skip_bres.sv
// One Bresenham accumulator step: emits the mask bit for the
// current slot and the accumulator for the next slot.
module skip_bres
   import skip_pkg::*;
#(
   parameter int LEN = LEN_DEF,
   parameter int CW  = CW_DEF
) (
   input  logic [CW-1:0] acc_i,
   input  logic [CW-1:0] neff_i,
   output logic [CW-1:0] acc_o,
   output logic          bit_o
);

   localparam logic [CW:0] LenW = (CW+1)'(LEN);

   logic [CW:0] sum;
   logic [CW:0] wrap;

   assign sum  = {1'b0, acc_i} + {1'b0, neff_i};
   assign wrap = sum - LenW;

   always_comb begin
      bit_o = 1'b0;
      acc_o = sum[CW-1:0];
      if (sum >= LenW) begin
         bit_o = 1'b1;
         acc_o = wrap[CW-1:0];
      end
   end

endmodule

// File: rtl/skip_ctrl.sv
// Control stage for the clock-skip ring: builds an evenly spread
// skip mask, commits it and reloads the ring with E held low.
module skip_ctrl
   import skip_pkg::*;
#(
   parameter int LEN = LEN_DEF,
   parameter int CW  = CW_DEF,
   parameter logic [LEN-1:0] SEL0 = {{(LEN-1){1'b0}}, 1'b1}
) (
   input  logic           iCLK,
   input  logic           RST,
   input  logic           WR,
   input  logic [CW-1:0]  CNT,
   input  logic           ENA,
   output logic [LEN-1:0] MASK,
   output logic [LEN-1:0] rSEL,
   output logic           oRST,
   output logic           oE,
   output logic           BUSY,
   output logic           DONE
);

   localparam int IW = $clog2(LEN);
   localparam logic [IW-1:0] LastIdx = IW'(LEN - 1);

   skip_state_e    state_q, state_d;
   logic [CW-1:0]  neff_q, neff_d;
   logic [CW-1:0]  acc_q, acc_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [LEN-1:0] shadow_q, shadow_d;
   logic [LEN-1:0] mask_q, mask_d;
   logic           pend_q, pend_d;
   logic [CW-1:0]  pcnt_q, pcnt_d;
   logic           orst_q, orst_d;
   logic           rsth_q;
   logic           oe_q, oe_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [CW-1:0]  cnt_eff;
   logic [CW-1:0]  bres_acc;
   logic           bres_bit;

   assign cnt_eff = CW'(clamp_cnt(int'(CNT), LEN));

   skip_bres #(
      .LEN (LEN),
      .CW  (CW)
   ) u_bres (
      .acc_i  (acc_q),
      .neff_i (neff_q),
      .acc_o  (bres_acc),
      .bit_o  (bres_bit)
   );

   always_comb begin
      state_d  = state_q;
      neff_d   = neff_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      mask_d   = mask_q;
      pend_d   = pend_q;
      pcnt_d   = pcnt_q;
      done_d   = 1'b0;

      if (WR && state_q != S_IDLE) begin
         pend_d = 1'b1;
         pcnt_d = cnt_eff;
      end

      unique case (state_q)
         S_IDLE: begin
            if (WR || pend_q) begin
               neff_d   = WR ? cnt_eff : pcnt_q;
               acc_d    = '0;
               idx_d    = '0;
               shadow_d = '0;
               pend_d   = 1'b0;
               state_d  = S_GEN;
            end
         end
         S_GEN: begin
            acc_d           = bres_acc;
            shadow_d[idx_q] = bres_bit;
            idx_d           = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
               // Registered so MASK is valid in the LOAD1 cycle.
               mask_d  = shadow_d;
               state_d = S_LOAD1;
            end
         end
         S_LOAD1: begin
            state_d = S_LOAD2;
         end
         S_LOAD2: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      oe_d   = (state_d == S_IDLE) && ENA;
      busy_d = (state_d != S_IDLE);
      orst_d = rsth_q || (state_d == S_LOAD1) || (state_d == S_LOAD2);
   end

   always_ff @(posedge iCLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         neff_q   <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         mask_q   <= '0;
         pend_q   <= 1'b0;
         pcnt_q   <= '0;
         orst_q   <= 1'b1;
         rsth_q   <= 1'b1;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         neff_q   <= neff_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         mask_q   <= mask_d;
         pend_q   <= pend_d;
         pcnt_q   <= pcnt_d;
         orst_q   <= orst_d;
         rsth_q   <= 1'b0;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign MASK = mask_q;
   assign rSEL = SEL0;
   assign oRST = orst_q;
   assign oE   = oe_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule
